fir_engine: RTL and testbench
=============================

// Module: fir_engine
// PURPOSE
//  Core datapath/FSM of FIR_main, downstream of AXI_main: AXI_main fills sample and coefficient RAMs;
//  on start (APB ctrl reg) this block computes y[n]=sum_k c[k]*x[n-k] (x[<0]=0) and writes results
//  to result RAM, which AXI_main reads back. Raises done pulse for FSM/APB status.
// PARAMETERS
//  DATA_W   16  signed sample/result width
//  COEF_W   16  signed coefficient width (Q1.(COEF_W-1))
//  ACC_W    40  accumulator width
//  ADDR_W   10  sample/result RAM address width
//  TAP_AW   6   coefficient RAM address width (max 64 taps)
//  FRAC     15  result right-shift before saturation
// PORTS
//  a_clk        in   1        clock; single clock domain (AXI domain B)
//  a_rst        in   1        synchronous active-high reset
//  start        in   1        1-cycle request; sampled only in IDLE
//  len          in   ADDR_W   number of outputs minus 1 (len=0 -> 1 output)
//  taps         in   TAP_AW   number of taps minus 1 (taps=0 -> 1 tap)
//  x_addr       out  ADDR_W   sample RAM read address
//  x_rdata      in   DATA_W   sample RAM data, valid 1 cycle after x_addr
//  c_addr       out  TAP_AW   coef RAM read address
//  c_rdata      in   COEF_W   coef RAM data, valid 1 cycle after c_addr
//  y_we         out  1        result RAM write enable
//  y_addr       out  ADDR_W   result RAM write address
//  y_wdata      out  DATA_W   result word
//  busy         out  1        high from cycle after accepted start until done
//  done         out  1        1-cycle pulse after last write
// BEHAVIOUR
//  Interface: one clock a_clk; reset a_rst is synchronous and active-high.
//  Reset: FSM->IDLE; busy,done,y_we=0; x_addr,c_addr,y_addr,y_wdata,acc,n,k=0. Reset mid-run
//   aborts immediately, no further writes, no done.
//  len/taps latched on accepted start; later changes ignored until next start.
//  States: IDLE -start-> MAC (n=0,k=0,acc=0)
//   MAC: each cycle issue x_addr=n-k, c_addr=k; raise rd_vld_q next cycle; k++; after k==taps -> DRAIN
//   DRAIN: 1 cycle, consumes final product
//   WRITE: y_we=1, y_addr=n, y_wdata=sat(acc>>>FRAC); if n==len -> DONE else n++,k=0,acc=0 -> MAC
//   DONE: done=1 one cycle, busy=0 -> IDLE
//  Accumulate: when rd_vld_q, acc += (mask_q ? 0 : x_rdata*c_rdata); mask_q registered = (k>n)
//   at issue (negative sample index; x_addr value don't-care but must stay in range, drive 0).
//  Arithmetic: full-precision signed product DATA_W+COEF_W, sign-extended to ACC_W; no acc wrap
//   for <=64 taps. Output: arithmetic shift right FRAC (truncate toward -inf), then saturate
//   to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Timing: per output taps+3 cycles (taps+1 MAC, 1 DRAIN, 1 WRITE); done asserted
//   (len+1)*(taps+3)+1 cycles after start cycle.
//  start while busy/DONE: ignored, no effect. start and a_rst same cycle: reset wins.
//  Exactly one y_we per output, addresses 0..len in increasing order; y_we never in IDLE/DONE.
//  x_addr=n-k computed in ADDR_W bits; no wrap because masked when k>n.
// STRUCTURE
//  pbl_fir_pkg: fir_state_e {IDLE,MAC,DRAIN,WRITE,DONE}; DATA_W/COEF_W/ACC_W/FRAC localparams;
//   function sat_round() shared with later FIR stages.
//  Sub-module fir_mac: registered multiply, mask, accumulate, clear; plus shift+saturate output.
//  fir_engine holds FSM, n/k counters, address generation, len/taps latches.
// TESTING
//  Impulse: x=[32767,0,0,0], c=[16384,8192,-8192], taps=2,len=3 -> y=[16383,8191,-8192,0].
//  Pass-through: taps=0,c[0]=32767, x=[100,-100,7], len=2 -> y=[99,-100,6]; done at cycle 3*3+1=10.
//  Saturation: taps=3, all c=32767, all x=32767, len=3 -> y[3]=32767; all x=-32768 -> y[3]=-32768.
//  len=0,taps=0: exactly one y_we at y_addr=0, done 4 cycles after start; busy high cycles 1-3.
//  start pulsed while busy, len/taps changed mid-run -> outputs/count identical to undisturbed run.
//  a_rst asserted during 2nd output's MAC -> next cycle IDLE, outputs 0, no done; new start runs clean.

Source files
------------

// File: rtl/pbl_fir_pkg.sv
// Shared FIR definitions: state encoding, default widths and the output
// shift/saturate helper used by this and later FIR stages.
package pbl_fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 40;
  localparam int FRAC   = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fir_state_e;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Arithmetic shift right by FRAC (floor), then clamp to the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > SAT_HI)
      sat_round = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < SAT_LO)
      sat_round = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_round = sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac.sv
// FIR multiply-accumulate: full-precision signed product, optional masking of
// taps that reach before the first sample, clear between outputs, and the
// shifted/saturated view of the accumulator presented to the result RAM.
module fir_mac
  import pbl_fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              vld,
  input  logic              mask,
  input  logic [DATA_W-1:0] x_rdata,
  input  logic [COEF_W-1:0] c_rdata,
  output logic [DATA_W-1:0] y_sat
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] ACC_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] x_s;
  logic signed [COEF_W-1:0] c_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // Floor shift by FRAC, then clamp into the signed DATA_W range.
  function automatic logic [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> FRAC;
    if (sh > ACC_HI)
      sat_shift = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < ACC_LO)
      sat_shift = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_shift = sh[DATA_W-1:0];
  endfunction

  // Product and next accumulator value; clear wins over accumulation.
  always_comb begin
    x_s      = signed'(x_rdata);
    c_s      = signed'(c_rdata);
    prod     = x_s * c_s;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_d    = acc_q;
    if (clr)
      acc_d = '0;
    else if (vld && !mask)
      acc_d = acc_q + prod_ext;
  end

  // Accumulator register (stage boundary: RAM data -> accumulated sum).
  always_ff @(posedge clk) begin
    if (rst)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  // Output word as it is written to the result RAM.
  always_comb begin
    y_sat = sat_shift(acc_q);
  end

endmodule

// File: rtl/fir_engine.sv
// FIR engine: sequences one output at a time over the sample and coefficient
// RAMs, accumulates sum_k c[k]*x[n-k] and writes each saturated result.
module fir_engine
  import pbl_fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 10,
  parameter int TAP_AW = 6,
  parameter int FRAC   = 15
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [TAP_AW-1:0] taps,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_rdata,
  output logic [TAP_AW-1:0] c_addr,
  input  logic [COEF_W-1:0] c_rdata,
  output logic              y_we,
  output logic [ADDR_W-1:0] y_addr,
  output logic [DATA_W-1:0] y_wdata,
  output logic              busy,
  output logic              done
);

  fir_state_e        state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [TAP_AW-1:0] k_q, k_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [TAP_AW-1:0] taps_q, taps_d;
  logic              rd_vld_q, rd_vld_d;
  logic              mask_q, mask_d;
  logic              acc_clr;
  logic [ADDR_W-1:0] k_ext;
  logic              neg_idx;
  logic [DATA_W-1:0] y_sat;

  // Next state, counters, RAM addressing and result-port drive.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    len_d    = len_q;
    taps_d   = taps_q;
    rd_vld_d = 1'b0;
    mask_d   = 1'b0;
    acc_clr  = 1'b0;
    x_addr   = '0;
    c_addr   = '0;
    y_we     = 1'b0;
    y_addr   = '0;
    y_wdata  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    k_ext    = {{(ADDR_W-TAP_AW){1'b0}}, k_q};
    neg_idx  = (k_ext > n_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          taps_d  = taps;
          n_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        busy     = 1'b1;
        c_addr   = k_q;
        // Taps reaching before x[0] read address 0 and are masked downstream.
        x_addr   = neg_idx ? '0 : (n_q - k_ext);
        rd_vld_d = 1'b1;
        mask_d   = neg_idx;
        if (k_q == taps_q)
          state_d = DRAIN;
        else
          k_d = k_q + 1'b1;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        y_we    = 1'b1;
        y_addr  = n_q;
        y_wdata = y_sat;
        if (n_q == len_q) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + 1'b1;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = MAC;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers (stage boundary: address issue -> RAM data valid).
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      k_q      <= '0;
      len_q    <= '0;
      taps_q   <= '0;
      rd_vld_q <= 1'b0;
      mask_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      len_q    <= len_d;
      taps_q   <= taps_d;
      rd_vld_q <= rd_vld_d;
      mask_q   <= mask_d;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .FRAC   (FRAC)
  ) u_mac (
    .clk     (a_clk),
    .rst     (a_rst),
    .clr     (acc_clr),
    .vld     (rd_vld_q),
    .mask    (mask_q),
    .x_rdata (x_rdata),
    .c_rdata (c_rdata),
    .y_sat   (y_sat)
  );

endmodule

// File: tb/tb_fir_engine.sv
// Testbench for fir_engine: RAM models, write/done monitor, and a plain
// convolution reference model.
module tb_fir_engine;

  logic        a_clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  len   = '0;
  logic [5:0]  taps  = '0;
  logic [9:0]  x_addr;
  logic [15:0] x_rdata = '0;
  logic [5:0]  c_addr;
  logic [15:0] c_rdata = '0;
  logic        y_we;
  logic [9:0]  y_addr;
  logic [15:0] y_wdata;
  logic        busy;
  logic        done;

  fir_engine dut (
    .a_clk   (a_clk),
    .a_rst   (a_rst),
    .start   (start),
    .len     (len),
    .taps    (taps),
    .x_addr  (x_addr),
    .x_rdata (x_rdata),
    .c_addr  (c_addr),
    .c_rdata (c_rdata),
    .y_we    (y_we),
    .y_addr  (y_addr),
    .y_wdata (y_wdata),
    .busy    (busy),
    .done    (done)
  );

  always #5 a_clk = ~a_clk;

  logic [15:0] xm [1024];
  logic [15:0] cm [64];
  logic [9:0]  ya [2048];
  logic [15:0] yd [2048];
  int cyc        = 0;
  int wr_n       = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int we_outside = 0;
  int total      = 0;
  int bad        = 0;

  // Synchronous-read RAMs and result/done monitor.
  always @(posedge a_clk) begin
    x_rdata <= xm[x_addr];
    c_rdata <= cm[c_addr];
    cyc     <= cyc + 1;
    if (y_we) begin
      if (wr_n < 2048) begin
        ya[wr_n] <= y_addr;
        yd[wr_n] <= y_wdata;
      end
      wr_n <= wr_n + 1;
      if (!busy) we_outside <= we_outside + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // y[n] = floor(sum_k c[k]*x[n-k] / 2^15) clamped to 16-bit signed.
  function automatic longint ref_y(input int n, input int tp);
    longint acc, s;
    acc = 0;
    for (int k = 0; k <= tp; k++)
      if (k <= n) acc += longint'($signed(xm[n-k])) * longint'($signed(cm[k]));
    s = acc >>> 15;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic load_rand(input int ln, input int tp);
    for (int i = 0; i <= ln; i++) xm[i] = 16'($urandom);
    for (int k = 0; k <= tp; k++) cm[k] = 16'($urandom);
  endtask

  task automatic run(input int ln, input int tp, input bit disturb, input string tag,
                     output int wb_o);
    int s, wb, db, lim, busy_bad, exp_done;
    wb = wr_n; db = done_cnt; wb_o = wb;
    exp_done = (ln + 1) * (tp + 3) + 1;
    lim = exp_done + 20;
    busy_bad = 0;
    @(posedge a_clk); #1;
    s = cyc; start = 1'b1; len = 10'(ln); taps = 6'(tp);
    for (int i = 0; i < lim; i++) begin
      @(posedge a_clk); #1;
      start = 1'b0;
      if (busy !== ((cyc > s) && (cyc < s + exp_done))) busy_bad++;
      if (done_cnt != db) break;
      if (disturb && (i % 4 == 1)) begin
        start = 1'b1; len = 10'($urandom); taps = 6'($urandom);
      end
    end
    chk({tag, ":done_cnt"}, done_cnt - db, 1);
    chk({tag, ":latency"}, done_cyc - s, exp_done);
    chk({tag, ":busy_window"}, busy_bad, 0);
    repeat (4) @(posedge a_clk);
    #1;
    chk({tag, ":nwrites"}, wr_n - wb, ln + 1);
    for (int i = 0; i <= ln; i++) begin
      chk($sformatf("%s:addr%0d", tag, i), ya[wb+i], i);
      chk($sformatf("%s:y%0d", tag, i), longint'($signed(yd[wb+i])), ref_y(i, tp));
    end
  endtask

  initial begin
    int wb, s, db;
    for (int i = 0; i < 1024; i++) xm[i] = '0;
    for (int i = 0; i < 64; i++)   cm[i] = '0;

    // Reset state
    repeat (3) @(posedge a_clk);
    #1;
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:y_we", y_we, 0);
    chk("rst:x_addr", x_addr, 0);
    chk("rst:c_addr", c_addr, 0);
    chk("rst:y_addr", y_addr, 0);
    chk("rst:y_wdata", y_wdata, 0);
    a_rst = 1'b0;

    // Impulse response
    xm[0] = 16'h7FFF; xm[1] = 16'h0; xm[2] = 16'h0; xm[3] = 16'h0;
    cm[0] = 16'h4000; cm[1] = 16'h2000; cm[2] = 16'hE000;
    run(3, 2, 1'b0, "impulse", wb);
    chk("impulse:c0", longint'($signed(yd[wb+0])), 16383);
    chk("impulse:c1", longint'($signed(yd[wb+1])), 8191);
    chk("impulse:c2", longint'($signed(yd[wb+2])), -8192);
    chk("impulse:c3", longint'($signed(yd[wb+3])), 0);

    // Single-tap pass-through
    cm[0] = 16'h7FFF; xm[0] = 16'd100; xm[1] = 16'hFF9C; xm[2] = 16'd7;
    run(2, 0, 1'b0, "pass", wb);
    chk("pass:c0", longint'($signed(yd[wb+0])), 99);
    chk("pass:c1", longint'($signed(yd[wb+1])), -100);
    chk("pass:c2", longint'($signed(yd[wb+2])), 6);

    // Saturation both directions
    for (int i = 0; i < 4; i++) begin cm[i] = 16'h7FFF; xm[i] = 16'h7FFF; end
    run(3, 3, 1'b0, "sat_pos", wb);
    chk("sat_pos:c3", longint'($signed(yd[wb+3])), 32767);
    for (int i = 0; i < 4; i++) xm[i] = 16'h8000;
    run(3, 3, 1'b0, "sat_neg", wb);
    chk("sat_neg:c3", longint'($signed(yd[wb+3])), -32768);

    // Minimal job
    xm[0] = 16'h1234; cm[0] = 16'h4000;
    run(0, 0, 1'b0, "min", wb);

    // Random jobs
    for (int r = 0; r < 4; r++) begin
      int ln, tp;
      ln = $urandom_range(0, 24);
      tp = $urandom_range(0, 15);
      load_rand(ln, tp);
      run(ln, tp, 1'b0, $sformatf("rand%0d", r), wb);
    end

    // Same job with start pulses and len/taps churn while busy
    load_rand(12, 9);
    run(12, 9, 1'b1, "disturb", wb);
    run(12, 9, 1'b0, "undisturbed", wb);

    // Reset during the second output's MAC phase
    load_rand(3, 4);
    wb = wr_n; db = done_cnt;
    @(posedge a_clk); #1;
    s = cyc; start = 1'b1; len = 10'd3; taps = 6'd4;
    for (int i = 0; i < 20 && cyc < s + 9; i++) begin
      @(posedge a_clk); #1;
      start = 1'b0;
    end
    a_rst = 1'b1;
    @(posedge a_clk); #1;
    a_rst = 1'b0;
    chk("abort:busy", busy, 0);
    chk("abort:y_we", y_we, 0);
    chk("abort:x_addr", x_addr, 0);
    chk("abort:c_addr", c_addr, 0);
    chk("abort:y_wdata", y_wdata, 0);
    chk("abort:done", done, 0);
    repeat (40) @(posedge a_clk);
    #1;
    chk("abort:writes", wr_n - wb, 1);
    chk("abort:no_done", done_cnt - db, 0);

    // start and reset in the same cycle: reset wins
    start = 1'b1; a_rst = 1'b1;
    @(posedge a_clk); #1;
    start = 1'b0; a_rst = 1'b0;
    chk("rst_start:busy0", busy, 0);
    @(posedge a_clk); #1;
    chk("rst_start:busy1", busy, 0);

    // Clean run after abort
    run(3, 4, 1'b0, "after_abort", wb);

    chk("we_outside_busy", we_outside, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
